// File: rtl/pac_motion_ctrl.sv
// Per-frame Pac-Man sprite sequencer: buffers joystick turns, steps the tile position and
// pulses the chomp shifter, deferring each update until the renderer is no longer drawing.
module pac_motion_ctrl #(
  parameter int STEP_DIV  = 4,
  parameter int CHOMP_DIV = 8,
  parameter int X_MAX     = 20,
  parameter int Y_MAX     = 15,
  parameter int START_X   = 9,
  parameter int START_Y   = 11
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       draw_busy,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  input  logic [3:0] blocked,
  output logic [1:0] rotation,
  output logic       shift_enable,
  output logic [4:0] pos_x,
  output logic [4:0] pos_y,
  output logic       moving,
  output logic       step,
  output logic       frame_overrun
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_DEFER  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       overrun_nxt;
  logic [3:0] step_cnt, chomp_cnt;
  logic       turn_pending;
  logic [1:0] next_dir;

  logic       turn_ok, mv, step_wrap, chomp_wrap;
  logic [1:0] dir_new;
  logic [4:0] x_nxt, y_nxt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_WAIT;
    else         state <= state_nxt;
  end

  // A tick landing in the UPDATE cycle is parked in DEFER so it is never lost.
  always_comb begin
    state_nxt   = state;
    overrun_nxt = 1'b0;
    case (state)
      S_WAIT:   if (frame_tick) state_nxt = draw_busy ? S_DEFER : S_UPDATE;
      S_DEFER: begin
        overrun_nxt = frame_tick;
        if (!draw_busy) state_nxt = S_UPDATE;
      end
      S_UPDATE: state_nxt = frame_tick ? S_DEFER : S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    turn_ok    = turn_pending && !blocked[next_dir];
    dir_new    = turn_ok ? next_dir : rotation;
    mv         = !blocked[dir_new];
    step_wrap  = (step_cnt == 4'(STEP_DIV - 1));
    chomp_wrap = (chomp_cnt == 4'(CHOMP_DIV - 1));
    x_nxt      = pos_x;
    y_nxt      = pos_y;
    case (dir_new)
      2'd0: x_nxt = (pos_x == 5'(X_MAX - 1)) ? 5'd0 : pos_x + 5'd1;
      2'd1: y_nxt = (pos_y == 5'd0) ? 5'd0 : pos_y - 5'd1;
      2'd2: x_nxt = (pos_x == 5'd0) ? 5'(X_MAX - 1) : pos_x - 5'd1;
      2'd3: y_nxt = (pos_y == 5'(Y_MAX - 1)) ? pos_y : pos_y + 5'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rotation      <= 2'd0;
      pos_x         <= 5'(START_X);
      pos_y         <= 5'(START_Y);
      moving        <= 1'b0;
      shift_enable  <= 1'b0;
      step          <= 1'b0;
      frame_overrun <= 1'b0;
      step_cnt      <= 4'd0;
      chomp_cnt     <= 4'd0;
      turn_pending  <= 1'b0;
      next_dir      <= 2'd0;
    end else begin
      shift_enable  <= 1'b0;
      step          <= 1'b0;
      frame_overrun <= overrun_nxt;
      if (state == S_UPDATE) begin
        rotation <= dir_new;
        moving   <= mv;
        if (turn_ok) turn_pending <= 1'b0;
        step_cnt <= step_wrap ? 4'd0 : step_cnt + 4'd1;
        if (step_wrap && mv) begin
          pos_x <= x_nxt;
          pos_y <= y_nxt;
          step  <= 1'b1;
        end
        if (mv) begin
          chomp_cnt    <= chomp_wrap ? 4'd0 : chomp_cnt + 4'd1;
          shift_enable <= chomp_wrap;
        end
      end
      // A strobe in the UPDATE cycle lands after the turn decision above.
      if (dir_valid) begin
        next_dir     <= dir_req;
        turn_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pac_motion_ctrl.sv
// Bench for pac_motion_ctrl: directed scenarios plus random traffic against a frame-level model.
module tb_pac_motion_ctrl;
  localparam int SD = 4, CD = 8, XM = 20, YM = 15, SX = 9, SY = 11;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0, draw_busy = 1'b0, dir_valid = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic [3:0] blocked = 4'd0;
  logic [1:0] rotation;
  logic       shift_enable, moving, step, frame_overrun;
  logic [4:0] pos_x, pos_y;

  pac_motion_ctrl dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .draw_busy(draw_busy),
    .dir_valid(dir_valid), .dir_req(dir_req), .blocked(blocked), .rotation(rotation),
    .shift_enable(shift_enable), .pos_x(pos_x), .pos_y(pos_y), .moving(moving),
    .step(step), .frame_overrun(frame_overrun)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int n_step, n_sh, n_ov;

  // Model: frame counts and plain modular arithmetic, advanced once per clock.
  int m_rot, m_x, m_y, m_nd, m_frames, m_mframes;
  bit m_mov, m_tp, m_upd, m_pend, m_sh, m_st, m_ov;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rot = 0; m_x = SX; m_y = SY; m_nd = 0; m_frames = 0; m_mframes = 0;
    m_mov = 0; m_tp = 0; m_upd = 0; m_pend = 0; m_sh = 0; m_st = 0; m_ov = 0;
  endtask

  task automatic model_step(input bit ft, input bit db, input bit dv,
                            input logic [1:0] dr, input logic [3:0] bl);
    bit nu, np, mv;
    m_sh = 0; m_st = 0; m_ov = 0;
    if (m_upd) begin
      if (m_tp && !bl[m_nd]) begin m_rot = m_nd; m_tp = 0; end
      mv = !bl[m_rot];
      m_mov = mv;
      m_frames++;
      if (mv && (m_frames % SD == 0)) begin
        m_st = 1;
        case (m_rot)
          0: m_x = (m_x + 1) % XM;
          1: m_y = (m_y > 0) ? m_y - 1 : 0;
          2: m_x = (m_x + XM - 1) % XM;
          default: m_y = (m_y < YM - 1) ? m_y + 1 : YM - 1;
        endcase
      end
      if (mv) begin
        m_mframes++;
        if (m_mframes % CD == 0) m_sh = 1;
      end
      nu = 0; np = ft;
    end else if (m_pend) begin
      m_ov = ft; nu = !db; np = db;
    end else begin
      nu = ft && !db; np = ft && db;
    end
    if (dv) begin m_nd = dr; m_tp = 1; end
    m_upd = nu; m_pend = np;
  endtask

  task automatic compare_all();
    chk("rotation", rotation, m_rot);
    chk("pos_x", pos_x, m_x);
    chk("pos_y", pos_y, m_y);
    chk("moving", moving, m_mov);
    chk("step", step, m_st);
    chk("shift_enable", shift_enable, m_sh);
    chk("frame_overrun", frame_overrun, m_ov);
    n_step += step; n_sh += shift_enable; n_ov += frame_overrun;
  endtask

  task automatic cyc(input bit ft, input bit db, input bit dv,
                     input logic [1:0] dr, input logic [3:0] bl);
    @(negedge clock);
    compare_all();
    resetn = 1'b1;
    frame_tick = ft; draw_busy = db; dir_valid = dv; dir_req = dr; blocked = bl;
    model_step(ft, db, dv, dr, bl);
  endtask

  // One tick followed by two idle cycles; on return its update is visible.
  task automatic ticks(input int n, input logic [3:0] bl);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0, bl);
      cyc(0, 0, 0, 0, bl);
      cyc(0, 0, 0, 0, bl);
    end
  endtask

  initial begin
    bit db_r;
    model_reset();
    n_step = 0; n_sh = 0; n_ov = 0;
    cyc(0, 0, 0, 0, 4'd0);

    // Free run right: steps on ticks 4 and 8, one mouth toggle.
    n_step = 0; n_sh = 0;
    ticks(8, 4'd0);
    chk("plan_steps", n_step, 2);
    chk("plan_chomp", n_sh, 1);
    chk("plan_x", pos_x, 11);

    // Turn up held off by a wall, taken once it clears.
    cyc(0, 0, 1, 2'd1, 4'b0010);
    ticks(3, 4'b0010);
    chk("turn_held", rotation, 0);
    ticks(1, 4'd0);
    chk("turn_taken", rotation, 1);

    // Back to right, then a wall ahead for 16 frames.
    cyc(0, 0, 1, 2'd0, 4'd0);
    ticks(1, 4'd0);
    n_step = 0; n_sh = 0;
    ticks(16, 4'b0001);
    chk("wall_steps", n_step, 0);
    chk("wall_chomp", n_sh, 0);
    chk("wall_moving", moving, 0);
    ticks(8, 4'd0);

    // Tunnel both ways, then saturate at the top edge.
    ticks(4 * 12, 4'd0);
    cyc(0, 0, 1, 2'd2, 4'd0);
    ticks(4 * 3, 4'd0);
    cyc(0, 0, 1, 2'd1, 4'd0);
    ticks(4 * 14, 4'd0);
    chk("top_sat_y", pos_y, 0);

    // Deferred tick with a second tick dropped while busy.
    n_ov = 0;
    cyc(1, 1, 0, 0, 4'd0);
    cyc(0, 1, 0, 0, 4'd0);
    cyc(1, 1, 0, 0, 4'd0);
    cyc(0, 1, 0, 0, 4'd0);
    cyc(0, 1, 0, 0, 4'd0);
    cyc(0, 0, 0, 0, 4'd0);
    cyc(0, 0, 0, 0, 4'd0);
    cyc(0, 0, 0, 0, 4'd0);
    chk("defer_overrun", n_ov, 1);

    // Reset mid-cycle while deferred with a turn pending.
    cyc(0, 0, 1, 2'd3, 4'd0);
    cyc(1, 1, 0, 0, 4'd0);
    cyc(0, 1, 0, 0, 4'd0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_rot", rotation, 0);
    chk("arst_x", pos_x, SX);
    chk("arst_y", pos_y, SY);
    chk("arst_step", step, 0);
    model_reset();
    cyc(0, 0, 0, 0, 4'd0);
    cyc(0, 0, 0, 0, 4'd0);
    ticks(1, 4'd0);
    chk("arst_no_turn", rotation, 0);

    // Random traffic.
    db_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 6 == 0) db_r = ~db_r;
      cyc(($urandom % 4) == 0, db_r, ($urandom % 10) == 0, 2'($urandom),
          4'($urandom & $urandom));
    end
    cyc(0, 0, 0, 0, 4'd0);
    cyc(0, 0, 0, 0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pac_motion_ctrl.md
# pac_motion_ctrl

Sequencer for the Pac-Man sprite. Once per video frame it applies buffered joystick turns, steps the tile position, and drives the `rotation` input of the chomp-animation shifter. It also drives that shifter's one-cycle `enable` pulse. Sits between the input decoder / maze-map lookup and the sprite renderer, and holds off updates while the renderer is drawing so a frame never shows a half-updated sprite.

## Interface
- `STEP_DIV`, default 4: frames per tile step; legal range 1–15.
- `CHOMP_DIV`, default 8: moving frames per mouth toggle; legal range 1–15.
- `X_MAX`, default 20: maze width in tiles; x wraps (tunnel).
- `Y_MAX`, default 15: maze height in tiles; y saturates.
- `START_X`, default 9: reset x tile.
- `START_Y`, default 11: reset y tile.
- `clock`  in  1  system clock.
- `resetn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `draw_busy`  in  1  renderer is reading sprite/position; no visible change allowed.
- `dir_valid`  in  1  joystick request strobe.
- `dir_req`  in  2  requested direction: 0 right, 1 up, 2 left, 3 down.
- `blocked`  in  4  wall flags for the neighbours of the current (`pos_x`, `pos_y`), indexed by direction; combinational from position, valid same cycle.
- `rotation`  out  2  current facing, drives the shifter's `rotation`.
- `shift_enable`  out  1  one-cycle pulse, drives the shifter's `enable`.
- `pos_x`  out  5  tile x.
- `pos_y`  out  5  tile y.
- `moving`  out  1  `!blocked[rotation]` as of the last update.
- `step`  out  1  one-cycle pulse on each tile move.
- `frame_overrun`  out  1  one-cycle pulse when a tick is dropped.

## Operation
- **Reset values:** `rotation`=0, `pos_x`=`START_X`, `pos_y`=`START_Y`. All of the following clear to 0: `shift_enable`, `step`, `moving`, `frame_overrun`, step counter, chomp counter, `turn_pending`, `next_dir`, `tick_pending`.
- **Turn buffer:**
  - Any cycle with `dir_valid`=1: `next_dir`<=`dir_req`, `turn_pending`<=1.
  - If several arrive before an update, the last one wins.
  - A request equal to the current `rotation` is still buffered, which is harmless.
- **States:**
  - WAIT:
    - `frame_tick`=1 and `draw_busy`=0 → UPDATE.
    - `frame_tick`=1 and `draw_busy`=1 → DEFER (`tick_pending`=1).
  - DEFER:
    - `draw_busy`=0 → UPDATE.
    - Another `frame_tick` while in DEFER is dropped and pulses `frame_overrun`; the pending tick is kept.
  - UPDATE: lasts exactly one cycle, then → WAIT. A `frame_tick` arriving in the UPDATE cycle is treated as in WAIT on the next cycle: it is latched to DEFER, never lost.
- **UPDATE actions** (all evaluated with `blocked` for the current position):
  1. Turn:
     - If `turn_pending` and `!blocked[next_dir]`: `rotation`<=`next_dir` and `turn_pending`<=0.
     - Otherwise the turn stays buffered for later frames.
  2. Let d = the rotation after step 1, and mv = `!blocked[d]`. `moving`<=mv.
  3. Step counter:
     - Increments every UPDATE, moving or not.
     - At `STEP_DIV`-1 it wraps to 0.
     - On wrap with mv=1, move one tile in direction d and pulse `step`.
  4. Chomp counter:
     - Increments only when mv=1; it freezes when mv=0, so the mouth holds.
     - At `CHOMP_DIV`-1 it wraps to 0 and pulses `shift_enable`.
- **Position arithmetic:**
  - Right: x==`X_MAX`-1 → 0, else x+1.
  - Left: x==0 → `X_MAX`-1, else x-1.
  - Up: y-1, saturating at 0.
  - Down: y+1, saturating at `Y_MAX`-1.
  - Saturated moves still pulse `step`.
- **Reset mid-operation:** reset in any state returns everything to the reset values immediately (asynchronous). The pending tick and the buffered turn are lost.
- The shifter's own reset is driven from `resetn` externally. This block does not reset the shifter.

## Timing
- UPDATE is entered on the clock edge after the accepted tick. Outputs are registered and change at the end of the UPDATE cycle: `frame_tick` in cycle N with `draw_busy`=0 gives new values visible from cycle N+2.
- `shift_enable`, `step`, `frame_overrun` are high for exactly one cycle.
- `shift_enable` and `step` coincide with the first cycle the new `rotation` / `pos` are visible.
- With `draw_busy` high, no output except `frame_overrun` changes until the cycle after `draw_busy` falls.
- `dir_valid` in the UPDATE cycle is captured after the turn decision. It applies at the next update.
- `blocked` is sampled only in the UPDATE cycle and must be settled for the current position there.

## Test plan
- Reset, then 8 ticks with `blocked`=0, `dir` idle:
  - `rotation`=0 throughout.
  - `step` pulses on ticks 4 and 8; `pos_x` goes 9→10→11.
  - `shift_enable` pulses once, on tick 8.
- Turn buffering: `dir_req`=1 strobe while `blocked[1]`=1 for 3 ticks, then `blocked[1]`=0:
  - `rotation` stays 0 for 3 ticks.
  - It becomes 1 at the 4th update.
  - `turn_pending` is cleared.
- Wall stop: `blocked[0]`=1 with `rotation`=0 for 16 ticks:
  - `moving`=0, no `step`, no `shift_enable`, position unchanged.
  - Then unblock: first `shift_enable` arrives after 8 further ticks.
- Tunnel wrap: x=19 moving right → 0; x=0 moving left → 19. Separately, y=0 moving up stays 0 with a `step` pulse.
- Draw deferral: tick with `draw_busy`=1 held 5 cycles, plus a second tick during busy:
  - No output change while busy.
  - `frame_overrun` pulses once.
  - Exactly one UPDATE occurs, 1 cycle after busy falls.
- Async reset asserted during DEFER with a turn pending:
  - Outputs return to reset values without a clock edge.
  - After release, no stale UPDATE or turn occurs.
